// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order fetches for the PC, pairs responses with their PCs,
// and hands (pc, instr) to decode. Optional same-cycle response bypass enabled by IFQ_BYPASS_EN.
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    output logic        pc_stay,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic          resetn_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] drop_cnt;
    logic [PW-1:0] count;
    logic [PW-1:0] outstanding;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] rd_idx;

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [DEPTH-1:0] filled;

    logic req_fire;
    logic rsp_fill;
    logic bypass_hit;
    logic pop;

    assign count       = wr_ptr - rd_ptr;
    assign outstanding = wr_ptr - fill_ptr;
    assign wr_idx      = wr_ptr[AW-1:0];
    assign fill_idx    = fill_ptr[AW-1:0];
    assign rd_idx      = rd_ptr[AW-1:0];

    // No new fetches while stale responses from before a redirect are still in flight.
    assign imem_req_valid = resetn & resetn_q & ~redirect & (count < PW'(DEPTH)) & (drop_cnt == '0);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pc_stay        = ~req_fire & ~redirect;
    assign rsp_fill       = imem_rsp_valid & (drop_cnt == '0);

    always_comb begin
        bypass_hit = 1'b0;
        id_pc      = pc_mem[rd_idx];
        id_instr   = instr_mem[rd_idx];
`ifdef IFQ_BYPASS_EN
        // A response landing in the unfilled head goes straight to decode this cycle.
        bypass_hit = rsp_fill & ~redirect & (count != '0) & (fill_ptr == rd_ptr);
        if (bypass_hit) begin
            id_instr = imem_rsp_data;
        end
`endif
        id_valid = ~redirect & (count != '0) & (filled[rd_idx] | bypass_hit);
    end

    assign pop = id_valid & id_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q <= 1'b0;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            filled   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            resetn_q <= 1'b1;
            if (redirect) begin
                // Everything still in flight becomes stale, including a response arriving now.
                rd_ptr   <= wr_ptr;
                fill_ptr <= wr_ptr;
                filled   <= '0;
                drop_cnt <= drop_cnt + outstanding - PW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc_mem[wr_idx] <= pc;
                    filled[wr_idx] <= 1'b0;
                    wr_ptr         <= wr_ptr + PW'(1);
                end
                if (imem_rsp_valid) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - PW'(1);
                    end else begin
                        instr_mem[fill_idx] <= imem_rsp_data;
                        filled[fill_idx]    <= 1'b1;
                        fill_ptr            <= fill_ptr + PW'(1);
                    end
                end
                // Placed after the fill so a bypassed pop leaves the entry unfilled.
                if (pop) begin
                    rd_ptr         <= rd_ptr + PW'(1);
                    filled[rd_idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed phases then random traffic, checked against a
// queue-based reference model and an in-order memory model.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic [31:0] pc;
    logic        pc_stay;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .pc             (pc),
        .pc_stay        (pc_stay),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of fetched PCs with the filled ones forming a prefix.
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    int          nfilled = 0;
    int          drop = 0;
    bit          rq = 1'b0;
    bit          in_reset = 1'b0;
    logic [31:0] cur_pc = 32'h0;
    int          cyc = 0;
    int          pops = 0;

    // Memory model: accepted addresses in order with their acceptance cycle.
    logic [31:0] mem_addr[$];
    int          mem_cyc[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit rst_n, input bit rdy, input bit rsp_en,
                                 input bit redir, input logic [31:0] target, input bit idr);
        bit          rsp;
        bit          exp_req;
        bit          fire;
        bit          byp;
        bit          exp_idv;
        logic [31:0] exp_instr;
        @(negedge clk);
        resetn         = rst_n;
        pc             = cur_pc;
        imem_req_ready = rdy;
        redirect       = redir;
        id_ready       = idr;
        rsp = rsp_en && rst_n && (mem_addr.size() > 0) && (mem_cyc[0] < cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_data(mem_addr[0]) : $urandom;
        #1;
        exp_req = rst_n && rq && !redir && (q_pc.size() < DEPTH) && (drop == 0);
        fire    = exp_req && rdy;
        byp     = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = !redir && (q_pc.size() > 0) && (nfilled == 0) && rsp && (drop == 0);
`endif
        exp_idv   = !redir && (q_pc.size() > 0) && ((nfilled > 0) || byp);
        exp_instr = 32'h0;
        if (exp_idv) exp_instr = byp ? imem_rsp_data : q_instr[0];

        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        check("pc_stay", {31'b0, pc_stay}, {31'b0, !fire && !redir});
        check("id_valid", {31'b0, id_valid}, {31'b0, exp_idv});
        if (exp_req) check("req_addr", imem_req_addr, cur_pc);
        if (exp_idv) begin
            check("id_pc", id_pc, q_pc[0]);
            check("id_instr", id_instr, exp_instr);
            if (idr) check("pop_instr_matches_pc", exp_instr, mem_data(q_pc[0]));
        end
        if (!rst_n && in_reset) begin
            check("reset_id_pc", id_pc, 32'h0);
            check("reset_id_instr", id_instr, 32'h0);
        end

        if (!rst_n) begin
            q_pc.delete();
            q_instr.delete();
            mem_addr.delete();
            mem_cyc.delete();
            nfilled  = 0;
            drop     = 0;
            rq       = 1'b0;
            cur_pc   = 32'h0;
            in_reset = 1'b1;
        end else begin
            rq       = 1'b1;
            in_reset = 1'b0;
            if (redir) begin
                drop = drop + (q_pc.size() - nfilled) - (rsp ? 1 : 0);
                q_pc.delete();
                q_instr.delete();
                nfilled = 0;
            end else begin
                if (rsp) begin
                    if (drop > 0) drop--;
                    else begin
                        q_instr[nfilled] = imem_rsp_data;
                        nfilled++;
                    end
                end
                if (exp_idv && idr) begin
                    void'(q_pc.pop_front());
                    void'(q_instr.pop_front());
                    nfilled--;
                    pops++;
                end
                if (fire) begin
                    q_pc.push_back(cur_pc);
                    q_instr.push_back(32'h0);
                end
            end
            if (rsp) begin
                void'(mem_addr.pop_front());
                void'(mem_cyc.pop_front());
            end
            if (fire) begin
                mem_addr.push_back(cur_pc);
                mem_cyc.push_back(cyc);
            end
            if (redir) cur_pc = target;
            else if (fire) cur_pc = cur_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        check(tag, obs, exp);
    endtask

    initial begin
        resetn         = 1'b0;
        pc             = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect       = 1'b0;
        id_ready       = 1'b0;
        repeat (2) @(posedge clk);
        in_reset = 1'b1;

        // Reset values.
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Streaming fetch with a one-cycle memory.
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("stream_pops", (pops >= 5) ? 1 : 0, 1);

        // Memory stalls requests: PC holds.
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Decode stalls until the queue is full, then a single pop frees one slot.
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("full_count", q_pc.size(), DEPTH);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Build outstanding requests, then redirect with a same-cycle response.
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
        checkOutput("drop_after_redirect", drop, mem_addr.size());
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Back-to-back redirects.
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of traffic.
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'b1, ($urandom % 4) != 0, ($urandom % 3) != 0,
                          ($urandom % 20) == 0, $urandom & 32'h0000FFFC, ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
